// File: rtl/xoodoo_pkg.sv
// Shared definitions for the Xoodoo duplex controller.
// - STATE_W / LANE_W : sponge state width and Xoodoo lane width.
// - PLANE*_LO        : bit offsets of the three 128-bit planes in the state.
// - DS_LO / DS_HI    : slice of the top state byte that carries the domain byte.
// - state_t          : controller FSM encoding.
package xoodoo_pkg;

    localparam int STATE_W   = 384;
    localparam int LANE_W    = 32;
    localparam int PLANE_W   = 4 * LANE_W;

    localparam int PLANE0_LO = 0;
    localparam int PLANE1_LO = PLANE_W;
    localparam int PLANE2_LO = 2 * PLANE_W;

    localparam int DS_LO     = STATE_W - 8;
    localparam int DS_HI     = STATE_W - 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        KICK      = 2'd1,
        WAIT_PERM = 2'd2,
        SQUEEZE   = 2'd3
    } state_t;

endpackage

// File: rtl/xoodoo_duplex_ctrl.sv
// Initiator-side sponge controller for one Xoodoo permutation core.
// Absorbs RATE_W-bit blocks into a 384-bit state, fires the permutation, and
// squeezes OUT_BLOCKS digest words after the final block.
//
// Ports:
//   clk, resetn            clock; asynchronous active-low reset
//   in_valid/in_ready      message block stream (in_data, in_last)
//   out_valid/out_ready    digest stream (out_data = state rate bits)
//   perm_enable            one-cycle request to the permutation core
//   perm_state             registered state fed to the core
//   perm_done/perm_result  core completion pulse and its result
//   busy                   controller is not in IDLE
//   error                  sticky permutation-timeout flag
//   dbg_state              current FSM state, for observation
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. A producer holds valid and its data stable until that edge;
// ready may be asserted independently of valid.
module xoodoo_duplex_ctrl
    import xoodoo_pkg::*;
#(
    parameter int         RATE_W     = 128,
    parameter int         OUT_BLOCKS = 2,
    parameter logic [7:0] DS_CONST   = 8'h01,
    parameter int         WAIT_LIMIT = 64
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [RATE_W-1:0]  in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [RATE_W-1:0]  out_data,
    output logic               perm_enable,
    output logic [STATE_W-1:0] perm_state,
    input  logic               perm_done,
    input  logic [STATE_W-1:0] perm_result,
    output logic               busy,
    output logic               error,
    output logic [1:0]         dbg_state
);

    localparam int             WCW       = $clog2(WAIT_LIMIT + 1);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(WAIT_LIMIT - 1);
    localparam logic [3:0]     OUT_N     = 4'(OUT_BLOCKS);

    state_t               fsm_q, fsm_d;
    logic [STATE_W-1:0]   st_q;
    logic [STATE_W-1:0]   st_absorb;
    logic                 last_q;
    logic [3:0]           sq_cnt_q;
    logic [3:0]           sq_next;
    logic [WCW-1:0]       wait_cnt_q;
    logic                 error_q;
    // Low while in reset and for the first cycle after it, so in_ready stays
    // low until the controller has seen a clock edge out of reset.
    logic                 run_q;

    logic                 absorb_go;
    logic                 done_go;
    logic                 tmo_go;
    logic                 sq_go;
    logic                 sq_end;

    assign sq_next   = sq_cnt_q + 4'd1;
    assign absorb_go = (fsm_q == IDLE) && run_q && in_valid;
    assign done_go   = (fsm_q == WAIT_PERM) && perm_done;
    assign tmo_go    = (fsm_q == WAIT_PERM) && !perm_done && (wait_cnt_q == WAIT_LAST);
    assign sq_go     = (fsm_q == SQUEEZE) && out_ready;
    assign sq_end    = sq_go && !(sq_next < OUT_N);

    // State after XOR-ing the offered block (and domain byte on the last one).
    always_comb begin
        st_absorb = st_q;
        st_absorb[RATE_W-1:0] = st_q[RATE_W-1:0] ^ in_data;
        if (in_last) begin
            st_absorb[DS_HI:DS_LO] = st_q[DS_HI:DS_LO] ^ DS_CONST;
        end
    end

    always_comb begin
        fsm_d       = fsm_q;
        in_ready    = 1'b0;
        perm_enable = 1'b0;
        out_valid   = 1'b0;
        case (fsm_q)
            IDLE: begin
                in_ready = run_q;
                if (absorb_go) begin
                    fsm_d = KICK;
                end
            end
            KICK: begin
                perm_enable = 1'b1;
                fsm_d       = WAIT_PERM;
            end
            WAIT_PERM: begin
                // A done in the final allowed cycle still wins over timeout.
                if (perm_done) begin
                    fsm_d = last_q ? SQUEEZE : IDLE;
                end else if (tmo_go) begin
                    fsm_d = IDLE;
                end
            end
            SQUEEZE: begin
                out_valid = 1'b1;
                if (sq_go) begin
                    fsm_d = sq_end ? IDLE : KICK;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fsm_q      <= IDLE;
            st_q       <= '0;
            last_q     <= 1'b0;
            sq_cnt_q   <= '0;
            wait_cnt_q <= '0;
            error_q    <= 1'b0;
            run_q      <= 1'b0;
        end else begin
            fsm_q <= fsm_d;
            run_q <= 1'b1;

            if (absorb_go) begin
                st_q <= st_absorb;
                if (in_last) begin
                    last_q <= 1'b1;
                end
            end

            if (fsm_q == KICK) begin
                wait_cnt_q <= '0;
            end else if (fsm_q == WAIT_PERM) begin
                wait_cnt_q <= wait_cnt_q + WCW'(1);
            end

            if (done_go) begin
                st_q <= perm_result;
            end

            if (tmo_go) begin
                st_q     <= '0;
                last_q   <= 1'b0;
                sq_cnt_q <= '0;
                error_q  <= 1'b1;
            end

            if (sq_go) begin
                if (sq_end) begin
                    st_q     <= '0;
                    last_q   <= 1'b0;
                    sq_cnt_q <= '0;
                end else begin
                    sq_cnt_q <= sq_next;
                end
            end
        end
    end

    assign perm_state = st_q;
    assign out_data   = st_q[RATE_W-1:0];
    assign busy       = (fsm_q != IDLE);
    assign error      = error_q;
    assign dbg_state  = fsm_q;

endmodule
